// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional parity support is controlled by the UART_RX_PARITY_EN macro in the users of this package.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_rx_state_e;

   localparam int CPB_MIN = 4;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-side result bundle: byte, frame pulses and busy flag.
// Macro UART_RX_PARITY_EN adds parity_err_o.
// Valid/ready: rx_valid_o is a one-cycle pulse with no ready; the consumer must take rx_data_o that cycle.
interface uart_rx_os_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] rx_data_o;
   logic              rx_valid_o;
   logic              sbit_o;
   logic              frame_err_o;
   logic              break_o;
   logic              busy_o;
`ifdef UART_RX_PARITY_EN
   logic              parity_err_o;
`endif

   modport master (
      output rx_data_o, rx_valid_o, sbit_o, frame_err_o, break_o, busy_o
`ifdef UART_RX_PARITY_EN
      , output parity_err_o
`endif
   );

   modport slave (
      input rx_data_o, rx_valid_o, sbit_o, frame_err_o, break_o, busy_o
`ifdef UART_RX_PARITY_EN
      , input parity_err_o
`endif
   );
endinterface

// File: rtl/uart_sync.sv
// Flop-chain synchroniser for an asynchronous level input; resets to 1 (idle line).
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) sync_q <= '1;
      else       sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start-bit validation, 2-of-3 majority per bit, framing/break detection.
// Macro UART_RX_PARITY_EN adds an optional parity bit between data and stop.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int CPB_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             rx_i,
   input  logic [CPB_W-1:0] clks_per_bit_i,
`ifdef UART_RX_PARITY_EN
   input  logic             parity_en_i,
   input  logic             parity_odd_i,
`endif
   uart_rx_os_if.master     rx_if
);
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CPB_W-1:0] ONE = CPB_W'(1);
   localparam logic [CPB_W-1:0] CPB_FLOOR = CPB_W'(CPB_MIN);

   uart_rx_state_e    state_q;
   logic [CPB_W-1:0]  cnt_q, cpb_q;
   logic [IDX_W-1:0]  bitidx_q;
   logic [DATA_W-1:0] shreg_q, data_q;
   logic [1:0]        smp_q;
   logic              armed_q;
   logic              valid_q, sbit_q, ferr_q, brk_q;
`ifdef UART_RX_PARITY_EN
   logic              par_en_q, par_odd_q, perr_pend_q, perr_q;
`endif

   logic             rx_s, maj;
   logic [CPB_W-1:0] cpb_d, half;
   logic             at_lo, at_mid, at_dec, at_end;

   uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (rx_i),
      .q_o   (rx_s)
   );

   assign cpb_d  = (clks_per_bit_i < CPB_FLOOR) ? CPB_FLOOR : clks_per_bit_i;
   assign half   = cpb_q >> 1;
   assign at_lo  = (cnt_q == half - ONE);
   assign at_mid = (cnt_q == half);
   assign at_dec = (cnt_q == half + ONE);
   assign at_end = (cnt_q == cpb_q - ONE);
   // Third vote is the live sample, so the bit is decided in the same cycle as its last sample.
   assign maj    = maj3(smp_q[1], smp_q[0], rx_s);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cpb_q    <= '0;
         bitidx_q <= '0;
         shreg_q  <= '0;
         data_q   <= '0;
         smp_q    <= '0;
         armed_q  <= 1'b0;
         valid_q  <= 1'b0;
         sbit_q   <= 1'b0;
         ferr_q   <= 1'b0;
         brk_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_en_q    <= 1'b0;
         par_odd_q   <= 1'b0;
         perr_pend_q <= 1'b0;
         perr_q      <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         sbit_q  <= 1'b0;
         ferr_q  <= 1'b0;
         brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
         // A low line only starts a frame once it has been seen high since the last frame error.
         if (rx_s) armed_q <= 1'b1;
         if (at_lo || at_mid) smp_q <= {smp_q[0], rx_s};

         if (!en_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (armed_q && !rx_s) begin
                     state_q <= START;
                     cnt_q   <= '0;
                     cpb_q   <= cpb_d;
`ifdef UART_RX_PARITY_EN
                     par_en_q  <= parity_en_i;
                     par_odd_q <= parity_odd_i;
`endif
                  end
               end
               START: begin
                  cnt_q <= cnt_q + ONE;
                  if (at_dec && maj) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else begin
                     if (at_dec) sbit_q <= 1'b1;
                     if (at_end) begin
                        state_q  <= DATA;
                        cnt_q    <= '0;
                        bitidx_q <= '0;
                     end
                  end
               end
               DATA: begin
                  cnt_q <= cnt_q + ONE;
                  if (at_dec) shreg_q <= {maj, shreg_q[DATA_W-1:1]};
                  if (at_end) begin
                     cnt_q <= '0;
                     if (bitidx_q == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= par_en_q ? PARITY : STOP;
`else
                        state_q <= STOP;
`endif
                     end else begin
                        bitidx_q <= bitidx_q + IDX_W'(1);
                     end
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  cnt_q <= cnt_q + ONE;
                  if (at_dec) perr_pend_q <= (^shreg_q) ^ maj ^ par_odd_q;
                  if (at_end) begin
                     state_q <= STOP;
                     cnt_q   <= '0;
                  end
               end
`endif
               STOP: begin
                  // Leave at mid-bit so the next start edge is caught with half a bit of margin.
                  if (at_dec) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     data_q  <= shreg_q;
                     armed_q <= maj;
                     if (maj) begin
                        valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_q  <= par_en_q & perr_pend_q;
`endif
                     end else begin
                        ferr_q <= 1'b1;
                        brk_q  <= ~|shreg_q;
                     end
                  end else begin
                     cnt_q <= cnt_q + ONE;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign rx_if.rx_data_o   = data_q;
   assign rx_if.rx_valid_o  = valid_q;
   assign rx_if.sbit_o      = sbit_q;
   assign rx_if.frame_err_o = ferr_q;
   assign rx_if.break_o     = brk_q;
   assign rx_if.busy_o      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_err_o = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frame vector table plus glitch, break, cpb-change, enable and reset sequences.
// Macro UART_RX_PARITY_EN enables the parity ports and the parity sequence.
module tb_uart_rx_os;
   logic        clk = 1'b0;
   logic        rst, en, rx;
   logic [15:0] cpb;
`ifdef UART_RX_PARITY_EN
   logic        par_en, par_odd;
`endif

   uart_rx_os_if #(.DATA_W(8)) rx_if ();

   uart_rx_os #(.DATA_W(8), .CPB_W(16), .SYNC_STAGES(2)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .en_i           (en),
      .rx_i           (rx),
      .clks_per_bit_i (cpb),
`ifdef UART_RX_PARITY_EN
      .parity_en_i    (par_en),
      .parity_odd_i   (par_odd),
`endif
      .rx_if          (rx_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pulse monitor, sampled mid-cycle
   int n_valid, n_sbit, n_ferr, n_brk, n_perr;
   int t_valid, t_sbit, t_ferr, t_brk, t_perr;

   task automatic clear_mon();
      n_valid = 0; n_sbit = 0; n_ferr = 0; n_brk = 0; n_perr = 0;
      t_valid = -1; t_sbit = -1; t_ferr = -1; t_brk = -1; t_perr = -1;
   endtask

   always @(negedge clk) begin
      logic perr;
      perr = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr = rx_if.parity_err_o;
`endif
      if (rx_if.rx_valid_o)  begin n_valid++; t_valid = cyc; end
      if (rx_if.sbit_o)      begin n_sbit++;  t_sbit  = cyc; end
      if (rx_if.frame_err_o) begin n_ferr++;  t_ferr  = cyc; end
      if (rx_if.break_o)     begin n_brk++;   t_brk   = cyc; end
      if (perr)              begin n_perr++;  t_perr  = cyc; end
      if (rx_if.rx_valid_o || rx_if.sbit_o || rx_if.frame_err_o || rx_if.break_o || perr) begin
         checks++;
         if ((int'(rx_if.rx_valid_o) + int'(rx_if.sbit_o) + int'(rx_if.frame_err_o) > 1) ||
             (rx_if.break_o && !rx_if.frame_err_o) || (perr && !rx_if.rx_valid_o)) begin
            errors++;
            $display("FAIL pulse_overlap at cycle %0d: valid=%b sbit=%b ferr=%b brk=%b perr=%b required legal combination",
                     cyc, rx_if.rx_valid_o, rx_if.sbit_o, rx_if.frame_err_o, rx_if.break_o, perr);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   // Drives one frame LSB first; e returns the cycle in which the synchronised line first reads low.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb_line,
                             input logic with_par, input logic par_bit, output int e);
      int n;
      n = with_par ? 11 : 10;
      @(posedge clk);
      #1;
      e = cyc + 2;
      for (int k = 0; k < n; k++) begin
         logic b;
         if (k == 0)                   b = 1'b0;
         else if (k <= 8)              b = d[k-1];
         else if (with_par && k == 9)  b = par_bit;
         else                          b = stop;
         rx = b;
         repeat (cpb_line) @(posedge clk);
         #1;
      end
      rx = 1'b1;
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         cpb_in;
      int         cpb_line;
      logic       exp_valid;
      logic       exp_ferr;
      logic       exp_brk;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int e;
      int h;
      vecs[0] = '{8'h55, 1'b1, 16, 16, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 16, 16, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'hFF, 1'b1,  8,  8, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'hA3, 1'b0, 16, 16, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h00, 1'b0, 16, 16, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{8'h3C, 1'b1,  2,  4, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'h81, 1'b1,  5,  5, 1'b1, 1'b0, 1'b0};

      rst = 1'b1; en = 1'b0; rx = 1'b1; cpb = 16'd16;
`ifdef UART_RX_PARITY_EN
      par_en = 1'b0; par_odd = 1'b0;
`endif
      clear_mon();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_data",  32'(rx_if.rx_data_o), 0);
      check("rst_valid", 32'(rx_if.rx_valid_o), 0);
      check("rst_sbit",  32'(rx_if.sbit_o), 0);
      check("rst_ferr",  32'(rx_if.frame_err_o), 0);
      check("rst_brk",   32'(rx_if.break_o), 0);
      check("rst_busy",  32'(rx_if.busy_o), 0);
`ifdef UART_RX_PARITY_EN
      check("rst_perr",  32'(rx_if.parity_err_o), 0);
`endif
      en = 1'b1;
      idle(5);

      for (int i = 0; i < 7; i++) begin
         clear_mon();
         cpb = 16'(vecs[i].cpb_in);
         h = vecs[i].cpb_line / 2;
         send_frame(vecs[i].d, vecs[i].stop, vecs[i].cpb_line, 1'b0, 1'b0, e);
         idle(2 * vecs[i].cpb_line + 10);
         check($sformatf("v%0d_sbit_cnt", i), n_sbit, 1);
         check($sformatf("v%0d_sbit_cyc", i), t_sbit, e + h + 3);
         check($sformatf("v%0d_valid_cnt", i), n_valid, 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_ferr_cnt", i), n_ferr, 32'(vecs[i].exp_ferr));
         check($sformatf("v%0d_brk_cnt", i), n_brk, 32'(vecs[i].exp_brk));
         check($sformatf("v%0d_data", i), 32'(rx_if.rx_data_o), 32'(vecs[i].d));
         check($sformatf("v%0d_done_cyc", i), vecs[i].exp_valid ? t_valid : t_ferr,
               e + 3 + 9 * vecs[i].cpb_line + h);
         check($sformatf("v%0d_busy", i), 32'(rx_if.busy_o), 0);
      end
      cpb = 16'd16;

      // 5-cycle low glitch on an idle line
      clear_mon();
      @(posedge clk);
      #1 rx = 1'b0;
      e = cyc + 2;
      repeat (5) @(posedge clk);
      #1 rx = 1'b1;
      wait_cyc(e + 5);
      check("glitch_busy_mid", 32'(rx_if.busy_o), 1);
      wait_cyc(e + 11);
      check("glitch_busy_end", 32'(rx_if.busy_o), 0);
      idle(20);
      check("glitch_sbit", n_sbit, 0);
      check("glitch_valid", n_valid, 0);
      check("glitch_ferr", n_ferr, 0);

      // Line held low for 20 bit times
      clear_mon();
      @(posedge clk);
      #1 rx = 1'b0;
      e = cyc + 2;
      repeat (20 * 16) @(posedge clk);
      #1 rx = 1'b1;
      idle(40);
      check("break_cnt", n_brk, 1);
      check("break_cyc", t_brk, e + 155);
      check("break_ferr_cnt", n_ferr, 1);
      check("break_valid", n_valid, 0);
      check("break_sbit", n_sbit, 1);
      check("break_busy", 32'(rx_if.busy_o), 0);

      // clks_per_bit_i raised mid-frame
      clear_mon();
      fork
         send_frame(8'h96, 1'b1, 16, 1'b0, 1'b0, e);
         begin
            repeat (60) @(posedge clk);
            #1 cpb = 16'd32;
         end
      join
      idle(40);
      check("cpbchg_valid", n_valid, 1);
      check("cpbchg_data", 32'(rx_if.rx_data_o), 32'h96);
      check("cpbchg_cyc", t_valid, e + 155);
      cpb = 16'd16;
      idle(5);

      // Enable dropped during data bit 4
      clear_mon();
      fork
         send_frame(8'h5A, 1'b1, 16, 1'b0, 1'b0, e);
         begin
            repeat (3 + 4 * 16 + 4) @(posedge clk);
            #1 en = 1'b0;
         end
      join
      idle(20);
      check("endrop_valid", n_valid, 0);
      check("endrop_ferr", n_ferr, 0);
      check("endrop_busy", 32'(rx_if.busy_o), 0);
      en = 1'b1;
      idle(5);

      // Reset pulsed during bit 6 of a frame whose tail is all high
      clear_mon();
      fork
         send_frame(8'hE3, 1'b1, 16, 1'b0, 1'b0, e);
         begin
            repeat (3 + 6 * 16 + 8) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check("rstmid_busy", 32'(rx_if.busy_o), 0);
            check("rstmid_data", 32'(rx_if.rx_data_o), 0);
         end
      join
      idle(20);
      check("rstmid_valid", n_valid, 0);
      check("rstmid_ferr", n_ferr, 0);

      clear_mon();
      send_frame(8'hFF, 1'b1, 16, 1'b0, 1'b0, e);
      idle(40);
      check("after_valid", n_valid, 1);
      check("after_data", 32'(rx_if.rx_data_o), 32'hFF);
      check("after_cyc", t_valid, e + 155);

`ifdef UART_RX_PARITY_EN
      // Even parity, 0x07 with parity bit 0
      clear_mon();
      par_en = 1'b1; par_odd = 1'b0;
      send_frame(8'h07, 1'b1, 16, 1'b1, 1'b0, e);
      idle(40);
      check("par_valid", n_valid, 1);
      check("par_err_cnt", n_perr, 1);
      check("par_same_cyc", t_perr, t_valid);
      check("par_cyc", t_valid, e + 3 + 10 * 16 + 8);
      check("par_data", 32'(rx_if.rx_data_o), 32'h07);
      par_en = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
